// File: rtl/cache_refill_ctrl.sv
// ============================================================================
// Module  : cache_refill_ctrl
// Brief   : Load-miss refill and store write-through controller for a
//           direct-mapped data cache; stalls the pipeline during memory access.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_refill_ctrl #(
    parameter int DATA_WIDTH        = 32,
    parameter int TAG_WIDTH         = 27,
    parameter int SET_ADDRESS_WIDTH = 3,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         req_valid,
    input  logic                         req_we,
    input  logic [3:0]                   req_be,
    input  logic [DATA_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]        req_wdata,
    input  logic                         hit,
    input  logic [DATA_WIDTH-1:0]        cache_rd,
    output logic                         stall,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         rdata_valid,
    output logic                         fill_en,
    output logic [SET_ADDRESS_WIDTH-1:0] fill_set,
    output logic [TAG_WIDTH-1:0]         fill_tag,
    output logic [DATA_WIDTH-1:0]        fill_data,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [3:0]                   mem_be,
    output logic [DATA_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic [CNT_WIDTH-1:0]         miss_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   merged_q, merged_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic                    hit_q, hit_d;
    logic                    store_q, store_d;
    logic [CNT_WIDTH-1:0]    miss_count_q, miss_count_d;
    logic [DATA_WIDTH-1:0]   w_merged;

    // Store data merged over the currently cached word, byte by byte
    always_comb begin
        w_merged = cache_rd;
        for (int i = 0; i < 4; i++) begin
            if (req_be[i]) begin
                w_merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            merged_q     <= '0;
            rd_q         <= '0;
            hit_q        <= 1'b0;
            store_q      <= 1'b0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            merged_q     <= merged_d;
            rd_q         <= rd_d;
            hit_q        <= hit_d;
            store_q      <= store_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        merged_d     = merged_q;
        rd_d         = rd_q;
        hit_d        = hit_q;
        store_d      = store_q;
        miss_count_d = miss_count_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_we) begin
                    addr_d   = req_addr;
                    be_d     = req_be;
                    wdata_d  = req_wdata;
                    merged_d = w_merged;
                    hit_d    = hit;
                    store_d  = 1'b1;
                    state_d  = S_WRITE;
                end else if (req_valid && !hit) begin
                    addr_d  = req_addr;
                    store_d = 1'b0;
                    if (miss_count_q != {CNT_WIDTH{1'b1}}) begin
                        miss_count_d = miss_count_q + CNT_WIDTH'(1);
                    end
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    rd_d    = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even if req_* toggle
    always_comb begin
        stall       = 1'b0;
        rdata       = '0;
        rdata_valid = 1'b0;
        fill_en     = 1'b0;
        fill_set    = '0;
        fill_tag    = '0;
        fill_data   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (RST) begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !req_we && hit) begin
                        rdata       = cache_rd;
                        rdata_valid = 1'b1;
                    end else if (req_valid) begin
                        stall = 1'b1;
                    end
                end
                S_READ: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_be   = 4'hF;
                    mem_addr = addr_q;
                end
                S_WRITE: begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_be    = be_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end
                S_RESP: begin
                    if (!store_q) begin
                        fill_en     = 1'b1;
                        fill_set    = addr_q[2 +: SET_ADDRESS_WIDTH];
                        fill_tag    = addr_q[DATA_WIDTH-1 -: TAG_WIDTH];
                        fill_data   = rd_q;
                        rdata       = rd_q;
                        rdata_valid = 1'b1;
                    end else if (hit_q) begin
                        fill_en   = 1'b1;
                        fill_set  = addr_q[2 +: SET_ADDRESS_WIDTH];
                        fill_tag  = addr_q[DATA_WIDTH-1 -: TAG_WIDTH];
                        fill_data = merged_q;
                    end
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign miss_count = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl (miss counter narrowed to 4 bits).
`default_nettype none

module tb_cache_refill_ctrl;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        hit;
    logic [31:0] cache_rd;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fill_en;
    logic [2:0]  fill_set;
    logic [26:0] fill_tag;
    logic [31:0] fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [3:0]  miss_count;

    int passed = 0;
    int total  = 0;
    logic [3:0] model_cnt = 4'd0;

    cache_refill_ctrl #(
        .DATA_WIDTH(32), .TAG_WIDTH(27), .SET_ADDRESS_WIDTH(3), .CNT_WIDTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_we(req_we), .req_be(req_be),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .hit(hit), .cache_rd(cache_rd),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .fill_en(fill_en), .fill_set(fill_set), .fill_tag(fill_tag), .fill_data(fill_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .miss_count(miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
        req_addr  = '0;   req_wdata = '0; hit = 1'b0; cache_rd = '0;
        mem_ack   = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle_inputs();
        step(); step();
        @(negedge CLK);
        total++; if (stall !== 1'b0) $display("FAIL rst_stall got=%0b exp=0", stall); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got=%0b exp=0", mem_req); else passed++;
        total++; if (miss_count !== 4'd0) $display("FAIL rst_miss_count got=%0h exp=0", miss_count); else passed++;
        step();
        RST = 1'b1;
        // start a load miss and abort it with reset while READ is active
        req_valid = 1'b1; req_addr = 32'h80; hit = 1'b0;
        step();
        @(negedge CLK);
        total++; if (mem_req !== 1'b1) $display("FAIL rst_read_req got=%0b exp=1", mem_req); else passed++;
        #1 RST = 1'b0;
        idle_inputs();
        #1;
        total++; if (mem_req !== 1'b0) $display("FAIL rst_async_req got=%0b exp=0", mem_req); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL rst_async_addr got=%0h exp=0", mem_addr); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rst_async_stall got=%0b exp=0", stall); else passed++;
        total++; if (miss_count !== 4'd0) $display("FAIL rst_async_cnt got=%0h exp=0", miss_count); else passed++;
        step();
        RST = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge CLK);
        total++; if (fill_en !== 1'b0) $display("FAIL rst_late_ack_fill got=%0b exp=0", fill_en); else passed++;
        step();
        idle_inputs();
        @(negedge CLK);
        total++; if (fill_en !== 1'b0 || rdata_valid !== 1'b0) $display("FAIL rst_after_ack fill=%0b rv=%0b exp=0/0", fill_en, rdata_valid); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rst_after_ack_stall got=%0b exp=0", stall); else passed++;
        model_cnt = 4'd0;
        step();
    endtask

    task automatic test_load_hit();
        req_valid = 1'b1; req_we = 1'b0; hit = 1'b1; req_addr = 32'h20; cache_rd = 32'hDEADBEEF;
        @(negedge CLK);
        total++; if (rdata !== 32'hDEADBEEF) $display("FAIL hit_rdata got=%0h exp=deadbeef", rdata); else passed++;
        total++; if (rdata_valid !== 1'b1) $display("FAIL hit_valid got=%0b exp=1", rdata_valid); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL hit_stall got=%0b exp=0", stall); else passed++;
        step();
        idle_inputs();
        @(negedge CLK);
        total++; if (miss_count !== model_cnt) $display("FAIL hit_cnt got=%0h exp=%0h", miss_count, model_cnt); else passed++;
        total++; if (rdata_valid !== 1'b0 || rdata !== 32'h0) $display("FAIL nohit_rdata rv=%0b rd=%0h exp=0/0", rdata_valid, rdata); else passed++;
        step();
    endtask

    task automatic test_load_miss();
        int stall_cycles;
        stall_cycles = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0044; hit = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'h12345678; end
            @(negedge CLK);
            if (stall === 1'b1) stall_cycles++;
            if (c == 0) begin
                total++; if (mem_req !== 1'b0) $display("FAIL miss_idle_req got=%0b exp=0", mem_req); else passed++;
            end
            if (c == 1) begin
                total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL miss_req req=%0b we=%0b exp=1/0", mem_req, mem_we); else passed++;
                total++; if (mem_addr !== 32'h44) $display("FAIL miss_addr got=%0h exp=44", mem_addr); else passed++;
                total++; if (mem_be !== 4'hF) $display("FAIL miss_be got=%0h exp=f", mem_be); else passed++;
            end
            step();
        end
        if (model_cnt != 4'hF) model_cnt++;
        idle_inputs();
        @(negedge CLK);
        total++; if (stall_cycles != 4) $display("FAIL miss_stall_cycles got=%0d exp=4", stall_cycles); else passed++;
        total++; if (fill_en !== 1'b1) $display("FAIL miss_fill_en got=%0b exp=1", fill_en); else passed++;
        total++; if (fill_set !== 3'd1) $display("FAIL miss_fill_set got=%0h exp=1", fill_set); else passed++;
        total++; if (fill_tag !== 27'd2) $display("FAIL miss_fill_tag got=%0h exp=2", fill_tag); else passed++;
        total++; if (fill_data !== 32'h12345678) $display("FAIL miss_fill_data got=%0h exp=12345678", fill_data); else passed++;
        total++; if (rdata !== 32'h12345678 || rdata_valid !== 1'b1) $display("FAIL miss_rdata got=%0h rv=%0b exp=12345678/1", rdata, rdata_valid); else passed++;
        total++; if (stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL miss_resp stall=%0b req=%0b exp=0/0", stall, mem_req); else passed++;
        total++; if (miss_count !== model_cnt) $display("FAIL miss_cnt got=%0h exp=%0h", miss_count, model_cnt); else passed++;
        step();
    endtask

    task automatic test_store_hit();
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0010; req_addr = 32'h48;
        req_wdata = 32'h0000AB00; cache_rd = 32'h11223344; hit = 1'b1;
        @(negedge CLK);
        total++; if (stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL sth_idle stall=%0b req=%0b exp=1/0", stall, mem_req); else passed++;
        step();
        mem_ack = 1'b1;
        @(negedge CLK);
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL sth_req req=%0b we=%0b exp=1/1", mem_req, mem_we); else passed++;
        total++; if (mem_be !== 4'b0010) $display("FAIL sth_be got=%0h exp=2", mem_be); else passed++;
        total++; if (mem_wdata !== 32'h0000AB00 || mem_addr !== 32'h48) $display("FAIL sth_wr wdata=%0h addr=%0h exp=ab00/48", mem_wdata, mem_addr); else passed++;
        step();
        idle_inputs();
        @(negedge CLK);
        total++; if (fill_en !== 1'b1) $display("FAIL sth_fill_en got=%0b exp=1", fill_en); else passed++;
        total++; if (fill_data !== 32'h1122AB44) $display("FAIL sth_fill_data got=%0h exp=1122ab44", fill_data); else passed++;
        total++; if (fill_set !== 3'd2 || fill_tag !== 27'd2) $display("FAIL sth_fill_idx set=%0h tag=%0h exp=2/2", fill_set, fill_tag); else passed++;
        total++; if (rdata_valid !== 1'b0 || stall !== 1'b0) $display("FAIL sth_resp rv=%0b stall=%0b exp=0/0", rdata_valid, stall); else passed++;
        step();
    endtask

    task automatic test_store_miss();
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h100;
        req_wdata = 32'hCAFEF00D; cache_rd = 32'h0; hit = 1'b0;
        @(negedge CLK);
        total++; if (stall !== 1'b1) $display("FAIL stm_idle_stall got=%0b exp=1", stall); else passed++;
        step();
        @(negedge CLK);
        total++; if (mem_be !== 4'hF || mem_wdata !== 32'hCAFEF00D) $display("FAIL stm_wr be=%0h wdata=%0h exp=f/cafef00d", mem_be, mem_wdata); else passed++;
        step();
        mem_ack = 1'b1;
        @(negedge CLK);
        total++; if (mem_req !== 1'b1 || stall !== 1'b1) $display("FAIL stm_hold req=%0b stall=%0b exp=1/1", mem_req, stall); else passed++;
        step();
        // next store presented during RESP, must be taken only in the following IDLE
        mem_ack = 1'b0; req_addr = 32'h104; req_be = 4'b0001; req_wdata = 32'h55;
        @(negedge CLK);
        total++; if (fill_en !== 1'b0 || fill_data !== 32'h0) $display("FAIL stm_nofill en=%0b data=%0h exp=0/0", fill_en, fill_data); else passed++;
        total++; if (stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL stm_resp stall=%0b req=%0b exp=0/0", stall, mem_req); else passed++;
        total++; if (miss_count !== model_cnt) $display("FAIL stm_cnt got=%0h exp=%0h", miss_count, model_cnt); else passed++;
        step();
        @(negedge CLK);
        total++; if (stall !== 1'b1) $display("FAIL stm_next_stall got=%0b exp=1", stall); else passed++;
        step();
        mem_ack = 1'b1;
        @(negedge CLK);
        total++; if (mem_addr !== 32'h104 || mem_be !== 4'b0001) $display("FAIL stm_next_wr addr=%0h be=%0h exp=104/1", mem_addr, mem_be); else passed++;
        step();
        idle_inputs();
        @(negedge CLK);
        total++; if (stall !== 1'b0) $display("FAIL stm_next_resp got=%0b exp=0", stall); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 17; i++) begin
            req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; req_addr = 32'(i) << 2;
            step();
            mem_ack = 1'b1; mem_rdata = 32'(i);
            step();
            idle_inputs();
            if (model_cnt != 4'hF) model_cnt++;
            step();
        end
        @(negedge CLK);
        total++; if (miss_count !== 4'hF) $display("FAIL sat_cnt got=%0h exp=f", miss_count); else passed++;
        total++; if (miss_count !== model_cnt) $display("FAIL sat_model got=%0h exp=%0h", miss_count, model_cnt); else passed++;
        req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; req_addr = 32'h3C;
        step();
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        req_valid = 1'b1; hit = 1'b1; req_addr = 32'h40; cache_rd = 32'h0BADF00D;
        @(negedge CLK);
        total++; if (rdata !== 32'hA5A5A5A5 || rdata_valid !== 1'b1) $display("FAIL b2b_resp rdata=%0h rv=%0b exp=a5a5a5a5/1", rdata, rdata_valid); else passed++;
        total++; if (fill_en !== 1'b1 || fill_set !== 3'd7 || fill_tag !== 27'd1) $display("FAIL b2b_fill en=%0b set=%0h tag=%0h exp=1/7/1", fill_en, fill_set, fill_tag); else passed++;
        step();
        @(negedge CLK);
        total++; if (rdata !== 32'h0BADF00D || rdata_valid !== 1'b1) $display("FAIL b2b_hit rdata=%0h rv=%0b exp=0badf00d/1", rdata, rdata_valid); else passed++;
        total++; if (stall !== 1'b0 || fill_en !== 1'b0) $display("FAIL b2b_hit_ctl stall=%0b fill=%0b exp=0/0", stall, fill_en); else passed++;
        total++; if (miss_count !== 4'hF) $display("FAIL b2b_cnt got=%0h exp=f", miss_count); else passed++;
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_load_hit();
        test_load_miss();
        test_store_hit();
        test_store_miss();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
